// File: rtl/flp_idiv_pkg.sv
// rtl/flp_idiv_pkg.sv - shared state encodings for the flp iterative divider
package flp_idiv_pkg;

  typedef enum logic [1:0] {
    FLP_IDIV_IDLE = 2'd0,
    FLP_IDIV_RUN  = 2'd1,
    FLP_IDIV_DONE = 2'd2
  } flp_idiv_state_e;

endpackage

// File: rtl/flp_idiv_stage.sv
// rtl/flp_idiv_stage.sv - combinational restoring-division slice resolving STEP quotient bits
module flp_idiv_stage #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [STEP-1:0]  bits_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [STEP-1:0]  q_out
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] r;
  logic             ge;

  // When the shifted value covers the divisor, the difference is below dvsr and
  // therefore fits WIDTH bits, so a modulo-WIDTH subtract is exact.
  always_comb begin
    r     = rem_in;
    q_out = '0;
    sh    = '0;
    ge    = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      sh       = {r, bits_in[i]};
      ge       = (sh >= {1'b0, dvsr});
      q_out[i] = ge;
      r        = ge ? (sh[WIDTH-1:0] - dvsr) : sh[WIDTH-1:0];
    end
    rem_out = r;
  end

endmodule

// File: rtl/flp_idiv.sv
// rtl/flp_idiv.sv - iterative unsigned divider, STEP quotient bits per clock, fixed latency
module flp_idiv
  import flp_idiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_dvnd,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_dz
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  flp_idiv_state_e state, nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvnd_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [STEP-1:0]  q_bits;
  logic [WIDTH-1:0] quot_nxt;
  logic             accept;
  logic             last;

  flp_idiv_stage #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_stage (
    .rem_in  (rem_q),
    .bits_in (dvnd_q[WIDTH-1 -: STEP]),
    .dvsr    (dvsr_q),
    .rem_out (rem_nxt),
    .q_out   (q_bits)
  );

  assign accept   = i_valid && o_ready;
  assign last     = (cnt == CW'(N - 1));
  // Quotient bits enter from the bottom as dividend bits leave from the top.
  assign quot_nxt = (dvnd_q << STEP) | WIDTH'(q_bits);

  always_ff @(posedge clk) begin
    if (!nrst) state <= FLP_IDIV_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      FLP_IDIV_IDLE: if (accept) nstate = FLP_IDIV_RUN;
      FLP_IDIV_RUN:  if (last)   nstate = FLP_IDIV_DONE;
      FLP_IDIV_DONE: nstate = accept ? FLP_IDIV_RUN : FLP_IDIV_IDLE;
      default:       nstate = FLP_IDIV_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state != FLP_IDIV_RUN);
    o_valid = (state == FLP_IDIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt    <= '0;
      dvnd_q <= '0;
      dvsr_q <= '0;
      rem_q  <= '0;
      o_quot <= '0;
      o_rem  <= '0;
      o_dz   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      dvnd_q <= i_dvnd;
      dvsr_q <= i_dvsr;
      rem_q  <= '0;
    end else if (state == FLP_IDIV_RUN) begin
      cnt    <= cnt + 1'b1;
      dvnd_q <= quot_nxt;
      rem_q  <= rem_nxt;
      if (last) begin
        o_quot <= quot_nxt;
        o_rem  <= rem_nxt;
        o_dz   <= (dvsr_q == '0);
      end
    end
  end

endmodule
